// File: rtl/decode_scoreboard_pkg.sv
// -----------------------------------------------------------------------------
// decode_scoreboard_pkg
// Shared types and constants for the decode-stage hazard scoreboard.
//   sb_entry_t  : one in-flight producer {valid, rd_addr, is_load}
//   FWD_SEL_RF  : forward-select code meaning "read the register file"
//   fwd_sel_w() : width of a forward-select field for a given tracking depth
// rd_addr is stored at SB_ADDR_MAX bits so one struct serves every
// REGISTER_SIZE up to that width; narrower addresses are zero-extended.
// -----------------------------------------------------------------------------
package decode_scoreboard_pkg;

  localparam int FWD_SEL_RF  = 0;
  localparam int SB_ADDR_MAX = 16;

  typedef struct packed {
    logic                   valid;
    logic [SB_ADDR_MAX-1:0] rd_addr;
    logic                   is_load;
  } sb_entry_t;

  // Codes 0..depth must be representable.
  function automatic int fwd_sel_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/decode_scoreboard_match.sv
// -----------------------------------------------------------------------------
// scoreboard_match
// For one source operand, finds the youngest in-flight entry that writes the
// operand's register and reports its stage index and whether it is a load.
// Ports:
//   eligible_i : source is valid, read, and not register 0
//   rs_addr_i  : source register (zero-extended)
//   entries_i  : scoreboard, index 0 = execute (stage 1)
//   sel_o      : youngest matching stage k (1-based), FWD_SEL_RF if none
//   is_load_o  : matching producer is a load
// -----------------------------------------------------------------------------
module scoreboard_match
  import decode_scoreboard_pkg::*;
#(
  parameter int FWD_DEPTH = 3,
  parameter int SEL_W     = 2
) (
  input  logic                   eligible_i,
  input  logic [SB_ADDR_MAX-1:0] rs_addr_i,
  input  sb_entry_t              entries_i [FWD_DEPTH],
  output logic [SEL_W-1:0]       sel_o,
  output logic                   is_load_o
);

  // Scan oldest to youngest so the youngest match is the last one written.
  always_comb begin
    sel_o     = SEL_W'(FWD_SEL_RF);
    is_load_o = 1'b0;
    if (eligible_i) begin
      for (int k = FWD_DEPTH; k >= 1; k--) begin
        if (entries_i[k-1].valid && (entries_i[k-1].rd_addr == rs_addr_i)) begin
          sel_o     = SEL_W'(k);
          is_load_o = entries_i[k-1].is_load;
        end
      end
    end
  end

endmodule

// File: rtl/decode_scoreboard.sv
// -----------------------------------------------------------------------------
// decode_scoreboard
// Decode-stage hazard unit: tracks destination registers of instructions in
// flight, selects forwarding sources per operand and stalls on load-use.
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   dec_valid             : decode holds a valid instruction
//   dec_rd_write/_addr    : instruction writes rd
//   dec_is_load           : instruction is a load
//   dec_rs_used/_addr     : per-source read flags and register numbers
//   flush                 : taken jump/branch, kills the decode instruction
//   f_to_d_enable_ff      : fetch-to-decode register enable
//   d_to_e_enable_ff      : 1 = decode instruction enters execute, 0 = bubble
//   pipeline_forward_sel  : per source, 0 = register file, k = stage k
//   stall_count           : saturating count of load-use stall cycles
// Handshake: the decode instruction advances when d_to_e_enable_ff is high;
// on a stall both enables drop and the same instruction is presented again.
// -----------------------------------------------------------------------------
module decode_scoreboard
  import decode_scoreboard_pkg::*;
#(
  parameter int REGISTER_SIZE = 5,
  parameter int NUM_SRC       = 2,
  parameter int FWD_DEPTH     = 3,
  parameter int LOAD_LAT      = 1,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic                                              dec_valid,
  input  logic                                              dec_rd_write,
  input  logic [REGISTER_SIZE-1:0]                          dec_rd_addr,
  input  logic                                              dec_is_load,
  input  logic [NUM_SRC-1:0]                                dec_rs_used,
  input  logic [NUM_SRC-1:0][REGISTER_SIZE-1:0]             dec_rs_addr,
  input  logic                                              flush,
  output logic                                              f_to_d_enable_ff,
  output logic                                              d_to_e_enable_ff,
  output logic [NUM_SRC-1:0][fwd_sel_w(FWD_DEPTH)-1:0]      pipeline_forward_sel,
  output logic [CNT_WIDTH-1:0]                              stall_count
);

  localparam int              SEL_W        = fwd_sel_w(FWD_DEPTH);
  localparam logic [SEL_W-1:0] LOAD_LAT_SEL = SEL_W'(LOAD_LAT);

  sb_entry_t                     entries_q [FWD_DEPTH];
  sb_entry_t                     entries_d [FWD_DEPTH];
  logic [CNT_WIDTH-1:0]          stall_count_q;
  logic [CNT_WIDTH-1:0]          stall_count_d;
  logic [NUM_SRC-1:0][SEL_W-1:0] match_sel;
  logic [NUM_SRC-1:0]            match_load;
  logic [NUM_SRC-1:0]            src_eligible;
  logic [NUM_SRC-1:0]            src_stall;
  logic                          stall;
  logic                          issue;

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    assign src_eligible[s] = dec_valid & dec_rs_used[s] & (dec_rs_addr[s] != '0);

    scoreboard_match #(
      .FWD_DEPTH (FWD_DEPTH),
      .SEL_W     (SEL_W)
    ) u_match (
      .eligible_i (src_eligible[s]),
      .rs_addr_i  (SB_ADDR_MAX'(dec_rs_addr[s])),
      .entries_i  (entries_q),
      .sel_o      (match_sel[s]),
      .is_load_o  (match_load[s])
    );

    // Load data becomes forwardable once the load is past stage LOAD_LAT.
    assign src_stall[s] = match_load[s] &&
                          (match_sel[s] != SEL_W'(FWD_SEL_RF)) &&
                          (match_sel[s] <= LOAD_LAT_SEL);
  end

  assign stall = |src_stall;
  assign issue = dec_valid & dec_rd_write & ~stall & ~flush & (dec_rd_addr != '0);

  always_comb begin
    entries_d[0] = '0;
    if (issue) begin
      entries_d[0].valid   = 1'b1;
      entries_d[0].rd_addr = SB_ADDR_MAX'(dec_rd_addr);
      entries_d[0].is_load = dec_is_load;
    end
    for (int k = 1; k < FWD_DEPTH; k++) begin
      entries_d[k] = entries_q[k-1];
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && !flush && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entries_q     <= '{default: '0};
      stall_count_q <= '0;
    end else begin
      entries_q     <= entries_d;
      stall_count_q <= stall_count_d;
    end
  end

  // Outputs are forced low while reset is held so the pipeline sees no
  // enables and no forwarding during reset.
  assign f_to_d_enable_ff     = ~rst & (flush | ~stall);
  assign d_to_e_enable_ff     = ~rst & dec_valid & ~stall & ~flush;
  assign pipeline_forward_sel = rst ? '0 : match_sel;
  assign stall_count          = stall_count_q;

endmodule
